uart_rx_core: RTL
=================

# uart_rx_core

Parametrised UART receive core: oversamples a serial line, frames characters of configurable length with optional parity and one or two stop bits, and presents each character on a valid/ready output with error flags. It replaces the fixed 8N1 receiver behind the board's serial input pin. Downstream consumers (display/command logic) read characters through the handshake rather than a free-running parallel bus.

## Interface

Parameters:
- CLK_DIV, 326: clk cycles per oversample tick (50 MHz / 9600 baud / 16 ≈ 326); legal ≥ 2.
- DATA_BITS, 8: data bits per character; legal 5–9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: reset, asynchronous, active-high.
- rx_in, in, 1: asynchronous serial line, idle high.
- data_out, out, DATA_BITS: received character, LSB = first bit on the line.
- data_valid, out, 1: data_out and the flags are valid.
- data_ready, in, 1: consumer accepts the character when data_valid && data_ready.
- parity_err, out, 1: parity mismatch on this character; 0 when PARITY = 0.
- frame_err, out, 1: a stop bit sampled low on this character.
- overrun, out, 1: sticky; at least one character dropped since last accept.
- busy, out, 1: FSM not in IDLE.

## Operation

- rx_in passes a 2-flop synchroniser; all logic uses the synchronised value rxs.
- Tick generator: counter 0..CLK_DIV-1, produces a 1-clk tick pulse at wrap. It is free-running and is restarted at count 0 when a start edge is detected.
- Within each bit the tick counter runs 0..15. The bit value is the majority of rxs sampled on ticks 7, 8, 9 and is committed on tick 9.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on rxs falling (1→0), go to START.
  - START: majority = 1 (glitch), return to IDLE with no output. Majority = 0, go to DATA at tick 15.
  - DATA: shift the majority value in LSB-first. After DATA_BITS bits, go to PARITY if PARITY ≠ 0, else to STOP.
  - PARITY: compare with even/odd parity of the data bits; the result is recorded in parity_err.
  - STOP: sample each stop bit. Any low stop bit sets frame_err. On the last stop bit's tick 9, load the output register and go to IDLE if rxs = 1, or to BREAK if rxs = 0.
  - BREAK: wait for rxs = 1, then go to IDLE. A new start is never detected while the line is held low.
- Output register: data_out, parity_err and frame_err load together with data_valid.
  - data_valid holds until the handshake completes.
  - If a character completes while data_valid = 1 and data_ready = 0, the new character is discarded, the old one is kept unchanged, and overrun is set.
  - If data_ready = 1 in the same cycle a new character completes, the handshake completes and the new character loads. There is no overrun.
  - overrun clears on the next completed handshake, unless another drop occurs in that same cycle.
- Characters with errors are still delivered, carrying their flags.

## Timing

- Reset: data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0. FSM goes to IDLE and all counters go to 0.
- Reset asserted mid-frame aborts the frame with no output. After release, the receiver waits for a fresh falling edge.
- Start edge recognised 2 clk after the rx_in edge (synchroniser delay).
- One bit period = 16 × CLK_DIV clk.
- data_valid rises 1 clk after tick 9 of the final stop bit.
- busy rises in the clk the FSM enters START and falls in the clk it returns to IDLE.
- Handshake accepts on the rising clk edge where valid && ready. data_valid drops the next cycle unless a new character loads in that cycle.
- Back-to-back characters with a single stop bit are received without loss.

## Structure

- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the FSM state enum rx_state_t;
  - OVERSAMPLE = 16 and the sample-tick constants 7/8/9.
- Sub-module uart_baud_tick: CLK_DIV counter with a synchronous restart input and a tick output. It is reusable by a future transmitter.
- The synchroniser, FSM, shift register and output buffer stay in uart_rx_core.

## Test plan

- CLK_DIV = 4, 8N1: send 0x55, ready held high → data_out = 0x55 with data_valid for 1 clk; parity_err = 0, frame_err = 0.
- PARITY = 1 (even), 8E1: send 0xA3 with parity bit 1 → parity_err = 1, data_out = 0xA3. Resend with parity bit 0 → parity_err = 0.
- Stop bit driven 0, line held low for 3 bit periods, then released → character delivered with frame_err = 1, FSM passes through BREAK, and no spurious second character appears.
- 3-tick low glitch on an idle line → busy pulses, data_valid never asserts.
- ready = 0: send 0x12 then 0x34 → data_out stays 0x12 and overrun = 1. Assert ready → accepted, overrun = 0. Then send 0x56 → data_out = 0x56.
- DATA_BITS = 7, STOP_BITS = 2: send 0x41 → data_out = 0x41. Assert reset mid-DATA of the next frame → all outputs return to 0 and the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants (parity modes, oversample/sample ticks) and rx FSM state type
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 0..CLK_DIV-1 counter; ports clk, reset (async), restart (sync, to 0), tick (1-clk pulse at wrap)
module uart_baud_tick #(
  parameter int CLK_DIV = 326
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver; ports clk, reset (async), rx_in, data_out/data_valid/data_ready handshake, parity_err, frame_err, overrun, busy
module uart_rx_core import uart_pkg::*; #(
  parameter int CLK_DIV = 326,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  rx_state_t state, state_n;
  logic rx_meta, rxs, rxs_d, fall, tick, restart, samp, bit_end, maj, last_stop, done, accept;
  logic s_a, s_b, stop_cnt, pe_r, fe_r;
  logic [3:0] os_cnt, bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(reset), .restart(restart), .tick(tick));
  assign fall = rxs_d & ~rxs;
  assign samp = tick && os_cnt == SAMPLE_C;
  assign bit_end = tick && os_cnt == OS_LAST;
  assign maj = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign done = state == RX_STOP && samp && last_stop;
  assign accept = data_valid & data_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) {rx_meta, rxs, rxs_d} <= 3'b111;
    else {rx_meta, rxs, rxs_d} <= {rx_in, rx_meta, rxs};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RX_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      RX_IDLE:   state_n = fall ? RX_START : RX_IDLE;
      RX_START:  state_n = (samp && maj) ? RX_IDLE : bit_end ? RX_DATA : RX_START;
      RX_DATA:   state_n = (bit_end && bit_cnt == 4'(DATA_BITS)) ? (PARITY != PAR_NONE ? RX_PARITY : RX_STOP) : RX_DATA;
      RX_PARITY: state_n = bit_end ? RX_STOP : RX_PARITY;
      RX_STOP:   state_n = done ? (rxs ? RX_IDLE : RX_BREAK) : RX_STOP;
      RX_BREAK:  state_n = rxs ? RX_IDLE : RX_BREAK;
      default:   state_n = RX_IDLE;
    endcase
  end
  always_comb begin
    busy = state != RX_IDLE;
    restart = state == RX_IDLE && fall;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      os_cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      s_a <= 1'b0;
      s_b <= 1'b0;
      shreg <= '0;
      pe_r <= 1'b0;
      fe_r <= 1'b0;
    end else begin
      if (restart) begin
        os_cnt <= '0;
        bit_cnt <= '0;
        stop_cnt <= 1'b0;
        pe_r <= 1'b0;
        fe_r <= 1'b0;
      end else if (tick) os_cnt <= os_cnt + 1'b1;
      if (tick && os_cnt == SAMPLE_A) s_a <= rxs;
      if (tick && os_cnt == SAMPLE_B) s_b <= rxs;
      if (samp && state == RX_DATA) begin
        shreg <= {maj, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (samp && state == RX_PARITY) pe_r <= (^shreg) ^ maj ^ (PARITY == PAR_ODD);
      if (samp && state == RX_STOP && !maj) fe_r <= 1'b1;
      if (bit_end && state == RX_STOP) stop_cnt <= 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_out <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (done && (!data_valid || data_ready)) begin
        data_out <= shreg;
        parity_err <= pe_r;
        frame_err <= fe_r | ~maj;
        data_valid <= 1'b1;
      end else if (accept) data_valid <= 1'b0;
      if (done && data_valid && !data_ready) overrun <= 1'b1;
      else if (accept) overrun <= 1'b0;
    end
endmodule
